// File: rtl/ppe_sync_if.sv
// ppe_sync_if: valid/ready packet channel.
// master drives valid/data, slave drives ready.
interface ppe_sync_if #(
  parameter int PKT_W = 30
);
  logic             valid;
  logic             ready;
  logic [PKT_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/ppe_sync.sv
// ppe_sync: clocked partial-sum PE sliding a filter row over a 1-bit ifmap row.
// Build macro PPE_DEST_CHECK_EN drops packets not addressed to PE_ID.
module ppe_sync #(
  parameter int FILTER_SIZE = 5,
  parameter int IFMAP_ROW   = 25,
  parameter int WEIGHT_W    = 8,
  parameter int SUM_W       = 14,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 25,
  parameter int NUM_SPE     = 5,
  parameter int SPE_BASE    = 0,
  parameter int IMEM_ID     = 10,
  parameter int PE_ID       = 0
) (
  input  logic        clk,
  input  logic        reset,
  ppe_sync_if.slave   in_p,
  ppe_sync_if.master  out_p,
`ifdef PPE_DEST_CHECK_EN
  output logic        drop_pulse,
`endif
  output logic        busy
);

  localparam int PKT_W   = ADDR_W + 1 + DATA_W;
  localparam int WPP     = DATA_W / WEIGHT_W;
  localparam int OUT_DIM = IFMAP_ROW - FILTER_SIZE + 1;
  localparam int WC_W    = $clog2(FILTER_SIZE + 1);
  localparam int J_W     = $clog2(OUT_DIM + 1);
  localparam int SI_W    = (NUM_SPE > 1) ? $clog2(NUM_SPE) : 1;

  localparam logic [WC_W-1:0] WC_FULL = WC_W'(FILTER_SIZE);
  localparam logic [J_W-1:0]  J_END   = J_W'(OUT_DIM);
  localparam logic [SI_W-1:0] SI_LAST = SI_W'(NUM_SPE - 1);
  localparam logic [PKT_W-1:0] REQ_PKT =
    {ADDR_W'(IMEM_ID), 1'b0, DATA_W'(0)};

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_REQ
  } state_t;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [PKT_W-1:0]     r_out_data;
  logic                 r_busy;
  logic [WC_W-1:0]      r_wcnt;
  logic [SI_W-1:0]      r_spe;
  logic [J_W-1:0]       r_j;
  logic [IFMAP_ROW-1:0] r_row;
  logic [WEIGHT_W-1:0]  r_wt [FILTER_SIZE];

  logic                   w_op;
  logic [DATA_W-1:0]      w_data;
  logic                   w_drop;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_wpkt;
  logic                   w_start;
  int                     w_base;
  logic [WC_W-1:0]        w_wcnt_nxt;
  logic [SI_W-1:0]        w_spe_next;
  logic [FILTER_SIZE-1:0] w_win;
  logic [SUM_W-1:0]       w_sum;
  logic [ADDR_W-1:0]      w_sum_addr;
  logic [PKT_W-1:0]       w_sum_pkt;

  assign w_op   = in_p.data[DATA_W];
  assign w_data = in_p.data[DATA_W-1:0];

`ifdef PPE_DEST_CHECK_EN
  logic r_drop;
  assign w_drop =
    in_p.data[PKT_W-1 -: ADDR_W] != ADDR_W'(PE_ID);
  assign drop_pulse = r_drop;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^in_p.data[PKT_W-1 -: ADDR_W];
  assign w_drop = 1'b0;
`endif

  assign w_in_fire  = in_p.valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_p.ready;
  assign w_wpkt     = !w_drop && !w_op;
  assign w_start    = !w_drop && w_op && (r_wcnt == WC_FULL);

  // A weight packet after a full set starts a fresh set at index 0.
  always_comb begin
    w_base = (r_wcnt == WC_FULL) ? 0 : int'(r_wcnt);
    w_wcnt_nxt = (w_base + WPP >= FILTER_SIZE) ?
      WC_FULL : WC_W'(w_base + WPP);
  end

  always_comb begin
    w_spe_next = r_spe;
    if (w_out_fire)
      w_spe_next = (r_spe == SI_LAST) ? '0 : r_spe + 1'b1;
  end

  always_comb begin
    w_win = FILTER_SIZE'(r_row >> r_j);
    w_sum = '0;
    for (int w = 0; w < FILTER_SIZE; w++)
      if (w_win[w])
        w_sum = w_sum + {{(SUM_W-WEIGHT_W){r_wt[w][WEIGHT_W-1]}},
                         r_wt[w]};
  end

  assign w_sum_addr = ADDR_W'(SPE_BASE + int'(w_spe_next));
  assign w_sum_pkt  = {w_sum_addr, 1'b0,
                       {{(DATA_W-SUM_W){w_sum[SUM_W-1]}}, w_sum}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_wcnt      <= '0;
      r_spe       <= '0;
      r_j         <= '0;
      r_row       <= '0;
      for (int i = 0; i < FILTER_SIZE; i++)
        r_wt[i] <= '0;
`ifdef PPE_DEST_CHECK_EN
      r_drop      <= 1'b0;
`endif
    end else begin
`ifdef PPE_DEST_CHECK_EN
      r_drop <= 1'b0;
`endif
      unique case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            unique case (1'b1)
              w_wpkt: begin
                for (int i = 0; i < FILTER_SIZE; i++)
                  for (int k = 0; k < WPP; k++)
                    if (i == w_base + k)
                      r_wt[i] <= w_data[k*WEIGHT_W +: WEIGHT_W];
                r_wcnt <= w_wcnt_nxt;
              end
              w_start: begin
                r_row      <= w_data[IFMAP_ROW-1:0];
                r_j        <= '0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= S_COMPUTE;
              end
              default: begin
`ifdef PPE_DEST_CHECK_EN
                r_drop <= w_drop;
`endif
              end
            endcase
          end
        end
        // Next packet is loaded as the current one leaves.
        S_COMPUTE: begin
          if (!r_out_valid || out_p.ready) begin
            r_out_valid <= 1'b1;
            r_spe       <= w_spe_next;
            if (r_j == J_END) begin
              r_out_data <= REQ_PKT;
              r_state    <= S_REQ;
            end else begin
              r_out_data <= w_sum_pkt;
              r_j        <= r_j + 1'b1;
            end
          end
        end
        S_REQ: begin
          if (out_p.ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_p.ready  = r_in_ready;
  assign out_p.valid = r_out_valid;
  assign out_p.data  = r_out_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ppe_sync.sv
// tb_ppe_sync: directed bench for ppe_sync.
// Drives and samples on the falling edge.
module tb_ppe_sync;

  localparam logic [3:0]  MY_ID = 4'd2;
  localparam logic [24:0] ONES  = 25'h1FFFFFF;
  localparam logic [24:0] W_A   = 25'h030201;
  localparam logic [24:0] W_B   = 25'h000504;
  localparam logic [24:0] W_NEG = 25'h808080;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   spe     = 0;
  int   exp_sum [21];

  ppe_sync_if #(.PKT_W(30)) in_if ();
  ppe_sync_if #(.PKT_W(30)) out_if ();

`ifdef PPE_DEST_CHECK_EN
  logic drop;
`endif

  ppe_sync #(.PE_ID(2)) dut (
    .clk        (clk),
    .reset      (rst),
    .in_p       (in_if),
    .out_p      (out_if),
`ifdef PPE_DEST_CHECK_EN
    .drop_pulse (drop),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] a, input logic op,
                      input logic [24:0] d);
    int n = 0;
    in_if.valid = 1'b1;
    in_if.data  = {a, op, d};
    while (!in_if.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_if.ready), 32'd1);
    @(negedge clk);
    in_if.valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!out_if.valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic recv(input string tag, input logic [29:0] exp);
    wait_ov();
    check({tag, "_valid"}, 32'(out_if.valid), 32'd1);
    check(tag, 32'(out_if.data), 32'(exp));
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check(tag, 32'(out_if.valid), 32'd0);
    end
  endtask

  task automatic recv_sums(input int cnt, input int stall);
    logic [24:0] d;
    for (int j = 0; j < cnt; j++) begin
      d = 25'(exp_sum[j]);
      if (j == stall) begin
        wait_ov();
        out_if.ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 32'(out_if.valid), 32'd1);
          check("stall_data", 32'(out_if.data),
                32'({4'(spe), 1'b0, d}));
        end
        out_if.ready = 1'b1;
      end
      recv("sum", {4'(spe), 1'b0, d});
      spe = (spe == 4) ? 0 : spe + 1;
    end
  endtask

  task automatic recv_row(input int stall);
    recv_sums(21, stall);
    recv("req", {4'd10, 1'b0, 25'd0});
  endtask

  task automatic fill(input int v);
    for (int j = 0; j < 21; j++) exp_sum[j] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_if.ready), 32'd0);
    check("rst_out_valid", 32'(out_if.valid), 32'd0);
    check("rst_out_data", 32'(out_if.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_up", 32'(in_if.ready), 32'd1);

    // input before any weights is swallowed
    send(MY_ID, 1'b1, ONES);
    idle("no_weights", 5);
    check("idle_busy", 32'(busy), 32'd0);

    send(MY_ID, 1'b0, W_A);
    send(MY_ID, 1'b0, W_B);
    send(MY_ID, 1'b1, ONES);
    check("busy", 32'(busy), 32'd1);
    fill(15);
    recv_row(-1);
    check("spe_after_row", spe, 1);
    send(MY_ID, 1'b1, ONES);
    recv_row(-1);

    // all -128 weights
    send(MY_ID, 1'b0, W_NEG);
    send(MY_ID, 1'b0, W_NEG);
    send(MY_ID, 1'b1, ONES);
    fill(-640);
    recv_row(-1);
    send(MY_ID, 1'b1, 25'h0000001);
    fill(0);
    exp_sum[0] = -128;
    recv_row(-1);

    // weights 1..5, single ifmap bit 7, stall at column 3
    send(MY_ID, 1'b0, W_A);
    send(MY_ID, 1'b0, W_B);
    send(MY_ID, 1'b1, 25'h0000080);
    fill(0);
    for (int j = 3; j <= 7; j++) exp_sum[j] = 8 - j;
    recv_row(3);

    // reset while column 10 is presented
    send(MY_ID, 1'b1, ONES);
    fill(15);
    recv_sums(10, -1);
    check("pre_rst_valid", 32'(out_if.valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_if.valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spe = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(in_if.ready), 32'd1);
    send(MY_ID, 1'b1, ONES);
    idle("post_rst_no_w", 5);
    send(MY_ID, 1'b0, W_A);
    send(MY_ID, 1'b0, W_B);
    send(MY_ID, 1'b1, ONES);
    recv_row(-1);

`ifdef PPE_DEST_CHECK_EN
    check("drop_idle", 32'(drop), 32'd0);
    send(4'd3, 1'b1, ONES);
    check("drop_pulse", 32'(drop), 32'd1);
    @(negedge clk);
    check("drop_clear", 32'(drop), 32'd0);
    idle("drop_no_sum", 4);
    send(MY_ID, 1'b1, ONES);
    recv_row(-1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
